// File: rtl/ram_line_master_pkg.sv
// Shared defaults, FSM state encodings and byte-lane helper for the line RAM requester.
package ram_line_master_pkg;

    localparam int unsigned DW_DEF   = 128;
    localparam int unsigned AW_DEF   = 16;
    localparam int unsigned PA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_WAIT  = 2'd1;
    localparam logic [1:0] ST_RMW_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    function automatic int unsigned lanes(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/line_byte_merge.sv
// Per-byte select between the line read from RAM and new write data.
module line_byte_merge
    import ram_line_master_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0]        i_old,
    input  logic [DW-1:0]        i_new,
    input  logic [lanes(DW)-1:0] i_mask,
    output logic [DW-1:0]        o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int b = 0; b < int'(lanes(DW)); b++) begin
            if (i_mask[b]) begin
                o_merged[b*8 +: 8] = i_new[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_line_master.sv
// Requester for the single-port line RAM: valid/ready request and response channels,
// byte-masked writes done as read-modify-write, one request outstanding.
module ram_line_master
    import ram_line_master_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned PA_W = PA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [PA_W-1:0]      req_addr,
    input  logic [DW-1:0]        req_wdata,
    input  logic [lanes(DW)-1:0] req_wmask,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DW-1:0]        resp_rdata,
    output logic                 resp_err,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_ren,
    output logic                 ram_wen,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata
);

    localparam int unsigned NB = lanes(DW);

    logic [1:0]    r_state;
    logic [DW-1:0] r_resp_rdata;
    logic          r_resp_err;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_wdata;
    logic [NB-1:0] r_wmask;

    logic [1:0]    w_state_d;
    logic [DW-1:0] w_rdata_d;
    logic          w_err_d;
    logic [AW-1:0] w_idx_d;
    logic [DW-1:0] w_wdata_d;
    logic [NB-1:0] w_wmask_d;

    logic          w_accept;
    logic          w_oor;
    logic          w_mask_full;
    logic          w_mask_zero;
    logic          w_partial;
    logic          w_rmw;
    logic [AW-1:0] w_req_idx;
    logic [DW-1:0] w_merged;
    logic          w_unused;

    assign w_unused = ^req_addr[3:0];

    if (PA_W > AW + 4) begin : g_hi_bits
        assign w_oor = |req_addr[PA_W-1:AW+4];
    end else begin : g_no_hi_bits
        assign w_oor = 1'b0;
    end

    assign w_req_idx   = req_addr[AW+3:4];
    assign w_mask_full = &req_wmask;
    assign w_mask_zero = ~|req_wmask;
    assign w_partial   = req_wr & ~w_mask_full & ~w_mask_zero;

    assign req_ready = (r_state == ST_IDLE) & rst_n;
    assign w_accept  = req_valid & req_ready;
    assign w_rmw     = (r_state == ST_RMW_WAIT);

    // Strobes are gated by rst_n so a reset mid-RMW never completes the write.
    assign ram_ren   = w_accept & ~w_oor & (~req_wr | w_partial);
    assign ram_wen   = rst_n & (w_rmw | (w_accept & ~w_oor & req_wr & w_mask_full));
    assign ram_addr  = w_rmw ? r_idx : w_req_idx;
    assign ram_wdata = w_rmw ? w_merged : req_wdata;

    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    line_byte_merge #(
        .DW (DW)
    ) u_merge (
        .i_old    (ram_rdata),
        .i_new    (r_wdata),
        .i_mask   (r_wmask),
        .o_merged (w_merged)
    );

    always_comb begin
        w_state_d = r_state;
        w_rdata_d = r_resp_rdata;
        w_err_d   = r_resp_err;
        w_idx_d   = r_idx;
        w_wdata_d = r_wdata;
        w_wmask_d = r_wmask;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_rdata_d = '0;
                    w_err_d   = w_oor;
                    if (w_oor) begin
                        w_state_d = ST_RESP;
                    end else if (!req_wr) begin
                        w_state_d = ST_RD_WAIT;
                    end else if (w_partial) begin
                        w_state_d = ST_RMW_WAIT;
                        w_idx_d   = w_req_idx;
                        w_wdata_d = req_wdata;
                        w_wmask_d = req_wmask;
                    end else begin
                        w_state_d = ST_RESP;
                    end
                end
            end
            ST_RD_WAIT: begin
                w_rdata_d = ram_rdata;
                w_state_d = ST_RESP;
            end
            ST_RMW_WAIT: begin
                w_state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_resp_rdata <= w_rdata_d;
            r_resp_err   <= w_err_d;
            r_idx        <= w_idx_d;
            r_wdata      <= w_wdata_d;
            r_wmask      <= w_wmask_d;
        end
    end

endmodule
